detector_tx: RTL and testbench
==============================

Name: detector_tx

Overview:
- Serializer for the detector link: the transmit end of the single-wire, de_clk-synchronous 12-bit word protocol consumed by detector_rx.
- Accepts 12-bit words through a valid/ready interface into a small FIFO.
- Frames each word as start bit, 12 data bits MSB first, then stop bit, and drives one DE_TX lane.
- One instance per lane (4 lanes in the camera top); also used as a bench stimulus source for detector_rx and row_reorder.

Parameters:
P_FIFO_DEPTH, 4, input FIFO depth in words; power of 2, minimum 2.
P_FIFO_AW, 2, FIFO address width; log2(P_FIFO_DEPTH).

Ports:
clk  input  1  link clock (de_clk domain); all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  transmit enable; low = finish current frame, then hold idle.
cmd_gap  input  8  idle cycles inserted after each stop bit (0 = back-to-back).
in_data  input  12  word to send.
in_valid  input  1  in_data valid.
in_ready  output  1  FIFO can accept; high when FIFO not full.
tx  output  1  serial line; registered output; idles low.
busy  output  1  high while in START, DATA, PAR, STOP or GAP.
fifo_level  output  P_FIFO_AW+1  words currently held in the FIFO.
tx_cnt  output  16  frames completed since reset; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, rst_n low): tx=0, busy=0, in_ready=0 while asserted, fifo_level=0, tx_cnt=0, FSM=IDLE, FIFO emptied. Reset mid-frame truncates the frame immediately; no partial stop bit is sent.
- After reset release, in_ready = !full.
- Push: occurs at any edge where in_valid && in_ready.
- in_ready depends on the registered full flag only. When full, there is no same-cycle push, even if a pop occurs that cycle.
- Simultaneous push and pop when not full: both occur and fifo_level is unchanged.
- FIFO read/write pointers wrap modulo P_FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR (feature only), STOP, GAP.
- IDLE: tx=0. If en && FIFO non-empty: pop the head into a 12-bit shift register, set tx=1, go to START.
- START: one cycle with tx=1. Next: tx=sr[11], bit counter=11, go to DATA.
- DATA: 12 cycles, MSB first. After bit 0, go to STOP (or PAR if the feature is enabled), tx=0.
- STOP: one cycle with tx=0; tx_cnt increments at the exit edge. Exit:
  - cmd_gap != 0: go to GAP with the gap counter loaded to cmd_gap.
  - cmd_gap == 0, en && FIFO non-empty: pop and go directly to START (back-to-back frames).
  - Otherwise: go to IDLE.
- GAP: tx=0. Decrement the counter; when it reaches 1, apply the same exit rule as cmd_gap==0 above.
- cmd_gap is sampled only when leaving STOP.
- Latency: word pushed into an empty FIFO at edge k while IDLE/en → start bit at edge k+1, bit11 at k+2 … bit0 at k+13, stop at k+14.
- Frame length: 14 cycles; throughput is 1 frame per 14+cmd_gap cycles.
- en deassert mid-frame: the current frame completes including GAP; no new pop occurs.
- tx_cnt counts only complete frames.

Optional Feature:
- Macro DETECTOR_TX_PARITY_EN.
- Defined: a PAR state follows DATA. It drives one even-parity bit (XOR of the 12 data bits) before STOP. Frame is 15 cycles; stop bit at k+15 in the latency example.
- Undefined: no PAR state; 14-cycle frame exactly as above.

Test Plan:
- Reset, en=1, cmd_gap=0, push 0xABC once → tx sequence 1,1,0,1,0,1,0,1,1,1,1,0,0,0 from edge k+1; tx_cnt=1; busy low after stop.
- Push 0x001, 0x800, 0xFFF back-to-back with cmd_gap=0 → three contiguous 14-cycle frames with no idle between them; paired detector_rx outputs exactly 0x001, 0x800, 0xFFF with wr pulses; tx_cnt=3.
- en=1, in_valid held high, cmd_gap=3, P_FIFO_DEPTH=4 → in_ready drops once fifo_level=4; no word is lost or duplicated over 10 words; 3 idle cycles between frames (17-cycle period).
- Deassert en during bit 5 of a frame with 2 words queued → frame completes, tx stays 0, fifo_level=2; re-assert en → start bit on the next edge.
- Assert rst_n=0 mid-DATA → tx=0 immediately, fifo_level=0, tx_cnt=0; after release, the next pushed word is sent as a full frame.
- With DETECTOR_TX_PARITY_EN, push 0x007 → parity bit 1 at cycle k+14, stop at k+15; push 0x003 → parity bit 0.

Source files
------------

// File: rtl/detector_tx.sv
// detector_tx: serializer for one detector link lane.
// Words enter through a valid/ready FIFO and leave as start bit (1),
// 12 data bits MSB first and a stop bit (0) on a registered, idle-low line,
// followed by cmd_gap idle cycles.
// Optional feature macro: DETECTOR_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit.
module detector_tx #(
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [7:0]           cmd_gap,
  input  logic [11:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [P_FIFO_AW:0]   fifo_level,
  output logic [15:0]          tx_cnt
);

  localparam logic [P_FIFO_AW:0] LP_FULL = (P_FIFO_AW + 1)'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_GAP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [11:0]            r_mem [P_FIFO_DEPTH];
  logic [P_FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [P_FIFO_AW:0]     r_level, w_level_nxt;
  logic                   r_full;
  logic [11:0]            r_sr, w_sr_nxt;
  logic [3:0]             r_bit, w_bit_nxt;
  logic [3:0]             w_bit_dec;
  logic [7:0]             r_gap, w_gap_nxt;
  logic                   r_tx, w_tx_nxt;
  logic [15:0]            r_cnt, w_cnt_nxt;
  logic                   w_push, w_pop, w_empty, w_launch, w_in_ready;

  // in_ready looks only at the registered full flag; held low during reset
  assign w_in_ready = rst_n & ~r_full;
  assign w_push     = in_valid & w_in_ready;
  assign w_empty    = (r_level == '0);
  assign w_launch   = en & ~w_empty;
  assign w_bit_dec  = r_bit - 4'd1;

  assign in_ready   = w_in_ready;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_level;
  assign tx_cnt     = r_cnt;

  // Frame sequencing: next state, shift register, counters, next tx value
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_tx_nxt    = r_tx;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b0;
        if (w_launch) begin
          w_pop       = 1'b1;
          w_sr_nxt    = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt    = r_sr[11];
        w_bit_nxt   = 4'd11;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (r_bit == 4'd0) begin
`ifdef DETECTOR_TX_PARITY_EN
          w_tx_nxt    = ^r_sr;
          w_state_nxt = S_PAR;
`else
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_tx_nxt  = r_sr[w_bit_dec];
          w_bit_nxt = w_bit_dec;
        end
      end
`ifdef DETECTOR_TX_PARITY_EN
      S_PAR: begin
        w_tx_nxt    = 1'b0;
        w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (cmd_gap != 8'd0) begin
          w_tx_nxt    = 1'b0;
          w_gap_nxt   = cmd_gap;
          w_state_nxt = S_GAP;
        end else if (w_launch) begin
          w_pop       = 1'b1;
          w_sr_nxt    = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        w_tx_nxt = 1'b0;
        if (r_gap == 8'd1) begin
          if (w_launch) begin
            w_pop       = 1'b1;
            w_sr_nxt    = r_mem[r_rd_ptr];
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap - 8'd1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy update for push/pop combinations
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // State, datapath and FIFO pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
      r_tx     <= 1'b0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_tx    <= w_tx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LP_FULL);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_detector_tx.sv
// Directed testbench for detector_tx.
module tb_detector_tx;

`ifdef DETECTOR_TX_PARITY_EN
  localparam int LEN = 15;
`else
  localparam int LEN = 14;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  cmd_gap;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] tx_cnt;

  int n_checks = 0;
  int n_errors = 0;

  detector_tx #(.P_FIFO_DEPTH(4), .P_FIFO_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmd_gap    (cmd_gap),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .tx_cnt     (tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line value at position i of a frame carrying w
  function automatic logic frame_bit(input logic [11:0] w, input int i);
    if (i == 0) return 1'b1;
    if (i >= 1 && i <= 12) return w[12-i];
`ifdef DETECTOR_TX_PARITY_EN
    if (i == 13) return ^w;
`endif
    return 1'b0;
  endfunction

  task automatic push_word(input logic [11:0] w);
    check("push_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Walk one whole frame starting at the next edge; optionally drop en after tick drop_at
  task automatic expect_frame(input logic [11:0] w, input int drop_at);
    for (int i = 0; i < LEN; i++) begin
      tick();
      check($sformatf("tx_%03h_b%0d", w, i), {31'd0, tx}, {31'd0, frame_bit(w, i)});
      if (i + 1 == drop_at) en = 1'b0;
    end
  endtask

  logic [11:0] wv [10];
  int          nxt;
  logic        rdy;
  logic        vld;

  initial begin
    wv = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF,
           12'h0F1, 12'hE2D, 12'h3C4, 12'hB5A, 12'h96E};
    rst_n    = 1'b0;
    en       = 1'b0;
    cmd_gap  = 8'd0;
    in_data  = '0;
    in_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_cnt", {16'd0, tx_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Single word 0xABC, back-to-back settings
    en = 1'b1;
    push_word(12'hABC);
    check("t1_level", {29'd0, fifo_level}, 32'd1);
    expect_frame(12'hABC, 0);
    check("t1_busy_stop", {31'd0, busy}, 32'd1);
    tick();
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_cnt", {16'd0, tx_cnt}, 32'd1);

    // Three queued words go out contiguously
    en = 1'b0;
    push_word(12'h001);
    push_word(12'h800);
    push_word(12'hFFF);
    check("t2_level", {29'd0, fifo_level}, 32'd3);
    check("t2_idle_tx", {31'd0, tx}, 32'd0);
    en = 1'b1;
    expect_frame(12'h001, 0);
    expect_frame(12'h800, 0);
    expect_frame(12'hFFF, 0);
    tick();
    check("t2_cnt", {16'd0, tx_cnt}, 32'd4);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // Backpressure with gap 3: fill to full, then stream 10 words
    en = 1'b0;
    cmd_gap = 8'd3;
    nxt = 0;
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = wv[nxt];
      rdy      = in_ready;
      tick();
      if (rdy) nxt++;
    end
    check("t3_full_level", {29'd0, fifo_level}, 32'd4);
    check("t3_full_ready", {31'd0, in_ready}, 32'd0);
    check("t3_full_taken", nxt, 32'd4);
    en = 1'b1;
    for (int t = 0; t < 10 * (LEN + 3); t++) begin
      vld      = (nxt < 10);
      in_valid = vld;
      in_data  = vld ? wv[nxt] : 12'h000;
      rdy      = in_ready;
      tick();
      if (vld && rdy) nxt++;
      check($sformatf("t3_tx_t%0d", t), {31'd0, tx},
            {31'd0, frame_bit(wv[t / (LEN + 3)], t % (LEN + 3))});
    end
    in_valid = 1'b0;
    check("t3_taken", nxt, 32'd10);
    check("t3_level", {29'd0, fifo_level}, 32'd0);
    check("t3_cnt", {16'd0, tx_cnt}, 32'd14);
    check("t3_busy_gap", {31'd0, busy}, 32'd1);
    tick();
    check("t3_busy_end", {31'd0, busy}, 32'd0);

    // Drop en during bit 5 with two words still queued
    cmd_gap = 8'd0;
    en = 1'b0;
    push_word(12'h5A5);
    push_word(12'h0F0);
    push_word(12'h3C3);
    en = 1'b1;
    expect_frame(12'h5A5, 8);
    check("t4_level_mid", {29'd0, fifo_level}, 32'd2);
    repeat (3) begin
      tick();
      check("t4_hold_tx", {31'd0, tx}, 32'd0);
      check("t4_hold_busy", {31'd0, busy}, 32'd0);
    end
    check("t4_level", {29'd0, fifo_level}, 32'd2);
    check("t4_cnt_hold", {16'd0, tx_cnt}, 32'd15);
    en = 1'b1;
    expect_frame(12'h0F0, 0);
    expect_frame(12'h3C3, 0);
    tick();
    check("t4_cnt", {16'd0, tx_cnt}, 32'd17);

    // Reset in the middle of DATA
    en = 1'b0;
    push_word(12'h9A6);
    push_word(12'h6B9);
    en = 1'b1;
    repeat (6) tick();
    check("t5_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", {31'd0, tx}, 32'd0);
    check("t5_rst_level", {29'd0, fifo_level}, 32'd0);
    check("t5_rst_cnt", {16'd0, tx_cnt}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("t5_hold_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b1;
    #1;
    push_word(12'h123);
    expect_frame(12'h123, 0);
    tick();
    check("t5_cnt", {16'd0, tx_cnt}, 32'd1);
    check("t5_level", {29'd0, fifo_level}, 32'd0);

    // Odd and even parity words (plain frames when parity is not built)
    push_word(12'h007);
    expect_frame(12'h007, 0);
    tick();
    push_word(12'h003);
    expect_frame(12'h003, 0);
    tick();
    check("t6_cnt", {16'd0, tx_cnt}, 32'd3);
    check("t6_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
